mem_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 22 ++
 rtl/data_mem.sv | 25 ++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, bus widths and the
// MEM-stage latency FSM encoding.
package mips_pkg;

  localparam int unsigned WB_REG_WRITE  = 1;
  localparam int unsigned WB_MEM_TO_REG = 0;
  localparam int unsigned M_BRANCH      = 2;
  localparam int unsigned M_MEM_READ    = 1;
  localparam int unsigned M_MEM_WRITE   = 0;

  localparam int unsigned WB_W   = 2;
  localparam int unsigned M_W    = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset
// on the array contents.
module data_mem
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: fixed-latency word load/store, branch resolution toward IF,
// upstream stall while an access is in flight, and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              stall_out,
  output logic              pc_src_out,
  output logic [DATA_W-1:0] branch_target_out,
  output logic [WB_W-1:0]   wb_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  dest_out,
  output logic              misalign_out
);

  localparam bit              MULTI_CYCLE = (MEM_LAT > 32'd1);
  // Only used when MULTI_CYCLE, so the wrap for MEM_LAT == 1 is harmless.
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT - 32'd2);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WB_W-1:0]   wb_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [REG_W-1:0]  dest_q;
  logic              misalign_q;

  logic              mem_op_c;
  logic              is_write_c;
  logic              misalign_c;
  logic              done_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] rdata_c;

  assign mem_op_c   = m_in[M_MEM_READ] | m_in[M_MEM_WRITE];
  assign is_write_c = m_in[M_MEM_WRITE];
  assign misalign_c = |alu_result_in[1:0];

  // The op completes (and MEM/WB takes a real beat) at the end of this cycle.
  assign done_c = (state_q == IDLE) ? (!mem_op_c || !MULTI_CYCLE)
                                    : (cnt_q == '0);

  // A reset in the completing cycle must not let the store land.
  assign mem_we_c = rst_n && done_c && mem_op_c && is_write_c && !misalign_c;

  assign stall_out         = !done_c;
  assign pc_src_out        = m_in[M_BRANCH] & zero_in;
  assign branch_target_out = pc_in;

  data_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_c),
    .addr_i  (alu_result_in[ADDR_W+1:2]),
    .wdata_i (rt_in),
    .rdata_o (rdata_c)
  );

  // Latency FSM and MEM/WB register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_q       <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      dest_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_c && MULTI_CYCLE) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (done_c) begin
        wb_q       <= wb_in;
        alu_q      <= alu_result_in;
        dest_q     <= dest_in;
        misalign_q <= mem_op_c & misalign_c;
        if (mem_op_c) begin
          rd_q <= misalign_c ? '0 : rdata_c;
        end
      end else begin
        wb_q       <= '0;
        misalign_q <= 1'b0;
      end
    end
  end

  assign wb_out         = wb_q;
  assign read_data_out  = rd_q;
  assign alu_result_out = alu_q;
  assign dest_out       = dest_q;
  assign misalign_out   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues the hand-computed MEM/WB
// beat of each op, the monitor pops it when the stage completes an op.
module tb_mem_stage;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] pc_in;
  logic        zero_in;
  logic [31:0] alu_result_in;
  logic [31:0] rt_in;
  logic [4:0]  dest_in;
  logic        stall_out;
  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic [1:0]  wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  dest_out;
  logic        misalign_out;

  mem_stage #(
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_in             (wb_in),
    .m_in              (m_in),
    .pc_in             (pc_in),
    .zero_in           (zero_in),
    .alu_result_in     (alu_result_in),
    .rt_in             (rt_in),
    .dest_in           (dest_in),
    .stall_out         (stall_out),
    .pc_src_out        (pc_src_out),
    .branch_target_out (branch_target_out),
    .wb_out            (wb_out),
    .read_data_out     (read_data_out),
    .alu_result_out    (alu_result_out),
    .dest_out          (dest_out),
    .misalign_out      (misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  wb;
    logic [31:0] rd;
    logic        rd_chk;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        mis;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   next_id = 0;
  logic vld    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  task automatic set_nop();
    wb_in = 2'b00; m_in = 3'b000; pc_in = '0; zero_in = 1'b0;
    alu_result_in = '0; rt_in = '0; dest_in = '0;
  endtask

  // Present one op (called just after a rising edge) and hold it until accepted.
  task automatic issue(input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] dest, input logic [31:0] pc,
                       input logic zero, input logic exp_pcsrc,
                       input logic [31:0] exp_rd, input logic rd_chk,
                       input logic exp_mis, input int lat);
    exp_t e;
    int   waited;
    wb_in = wb; m_in = m; alu_result_in = alu; rt_in = rt; dest_in = dest;
    pc_in = pc; zero_in = zero; vld = 1'b1;
    e.id = next_id; e.wb = wb; e.rd = exp_rd; e.rd_chk = rd_chk; e.alu = alu;
    e.dest = dest; e.mis = exp_mis; e.lat = lat; e.issue_cyc = cyc;
    sb.push_back(e);
    next_id++;
    @(negedge clk);
    chk($sformatf("op%0d_pc_src", e.id), 32'(pc_src_out), 32'(exp_pcsrc));
    chk($sformatf("op%0d_br_target", e.id), branch_target_out, pc);
    waited = 0;
    while (stall_out && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (stall_out) begin
      n_vec++; n_err++;
      $display("FAIL op%0d_stall_timeout: stall_out still 1 after %0d cycles", e.id, waited);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    set_nop();
  endtask

  // Store accepted, then reset k cycles later while the store is held.
  task automatic rst_store(input int k, input logic [31:0] addr, input logic [31:0] data);
    wb_in = 2'b00; m_in = 3'b001; alu_result_in = addr; rt_in = data;
    dest_in = 5'd0; pc_in = '0; zero_in = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_nop();
    #1;
    chk($sformatf("rst%0d_stall", k), 32'(stall_out), 32'd0);
    chk($sformatf("rst%0d_wb", k), 32'(wb_out), 32'd0);
    chk($sformatf("rst%0d_rd", k), read_data_out, 32'd0);
    chk($sformatf("rst%0d_alu", k), alu_result_out, 32'd0);
    chk($sformatf("rst%0d_dest", k), 32'(dest_out), 32'd0);
    chk($sformatf("rst%0d_mis", k), 32'(misalign_out), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a real beat follows every cycle where a valid op sees stall_out=0.
  initial begin
    logic comp;
    int   c;
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld && rst_n) begin
        comp = !stall_out;
        c    = cyc;
        @(posedge clk);
        #2;
        if (comp) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_underflow: beat seen with empty scoreboard");
          end else begin
            e = sb.pop_front();
            chk($sformatf("op%0d_latency", e.id), 32'(c - e.issue_cyc), 32'(e.lat - 1));
            chk($sformatf("op%0d_wb", e.id), 32'(wb_out), 32'(e.wb));
            chk($sformatf("op%0d_alu", e.id), alu_result_out, e.alu);
            chk($sformatf("op%0d_dest", e.id), 32'(dest_out), 32'(e.dest));
            chk($sformatf("op%0d_mis", e.id), 32'(misalign_out), 32'(e.mis));
            if (e.rd_chk) chk($sformatf("op%0d_rd", e.id), read_data_out, e.rd);
          end
        end else begin
          chk("bubble_wb", 32'(wb_out), 32'd0);
          chk("bubble_mis", 32'(misalign_out), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall_out), 32'd0);
    chk("reset_wb", 32'(wb_out), 32'd0);
    chk("reset_rd", read_data_out, 32'd0);
    chk("reset_alu", alu_result_out, 32'd0);
    chk("reset_dest", 32'(dest_out), 32'd0);
    chk("reset_mis", 32'(misalign_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    wb     m       alu           rt            dst    pc      z     pcs   exp_rd        chk   mis   lat
    issue(2'b00, 3'b001, 32'h10,       32'hDEADBEEF, 5'd0,  32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3);
    issue(2'b11, 3'b010, 32'h10,       32'h0,        5'd7,  32'h0,  1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 3);
    issue(2'b11, 3'b010, 32'h410,      32'h0,        5'd9,  32'h0,  1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 3);
    issue(2'b11, 3'b010, 32'h13,       32'h0,        5'd3,  32'h0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3);
    issue(2'b00, 3'b001, 32'h12,       32'h11111111, 5'd0,  32'h0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3);
    issue(2'b11, 3'b010, 32'h10,       32'h0,        5'd4,  32'h0,  1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 3);
    issue(2'b00, 3'b001, 32'h3FC,      32'hCAFEF00D, 5'd0,  32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3);
    issue(2'b11, 3'b010, 32'h3FC,      32'h0,        5'd31, 32'h0,  1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 3);
    issue(2'b00, 3'b011, 32'h20,       32'hAAAA5555, 5'd0,  32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3);
    issue(2'b11, 3'b010, 32'h20,       32'h0,        5'd12, 32'h0,  1'b0, 1'b0, 32'hAAAA5555, 1'b1, 1'b0, 3);
    issue(2'b00, 3'b100, 32'h1234,     32'h0,        5'd0,  32'h40, 1'b1, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1);
    issue(2'b00, 3'b100, 32'h5678,     32'h0,        5'd0,  32'h80, 1'b0, 1'b0, 32'hAAAA5555, 1'b1, 1'b0, 1);
    for (int i = 1; i <= 4; i++) begin
      issue(2'b10, 3'b000, 32'(i * 32'h111), 32'h0, 5'(i + 10), 32'h0, 1'b0, 1'b0,
            32'hAAAA5555, 1'b1, 1'b0, 1);
    end

    rst_store(1, 32'h20, 32'h12345678);
    issue(2'b11, 3'b010, 32'h20,       32'h0,        5'd13, 32'h0,  1'b0, 1'b0, 32'hAAAA5555, 1'b1, 1'b0, 3);
    rst_store(2, 32'h20, 32'h87654321);
    issue(2'b11, 3'b010, 32'h20,       32'h0,        5'd14, 32'h0,  1'b0, 1'b0, 32'hAAAA5555, 1'b1, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
